mem_scan_checker: RTL and testbench
===================================

# mem_scan_checker

Read-back scanner on the test port of the 64K×32 word memory. On a `go` pulse it walks a contiguous address range through the memory's read path and accumulates a 32-bit additive checksum and a nonzero-word census over that range. The decoder/loader writes the memory; this block then verifies what was written, without a CPU or testbench reading words one by one.

## Interface
- `ADDR_W`, 16: memory address width; must equal the memory's `memory_size`.
- `WORD_W`, 32: memory word width; must equal the memory's `word_size`.

Ports:
- `clk`  in  1: rising-edge clock shared with the memory.
- `reset`  in  1: asynchronous, active-low; clears all state and outputs immediately.
- `go`  in  1: start request, sampled in IDLE only.
- `base_addr`  in  ADDR_W: first address to read, latched on accepted `go`.
- `num_words`  in  ADDR_W+1: word count, 0..2^ADDR_W, latched on accepted `go`.
- `mem_rwn`  out  1: drives the memory `rwn` input; 1 only while issuing reads.
- `mem_addr`  out  ADDR_W: drives the memory `address_test` input.
- `mem_rdata`  in  WORD_W: the memory `data_out`.
- `busy`  out  1: high from the accepted `go` until `done`, inclusive.
- `done`  out  1: one-cycle pulse when results are final.
- `checksum`  out  WORD_W: sum of all words read, mod 2^WORD_W.
- `nz_count`  out  ADDR_W+1: number of words read that are not zero.
- `found_nz`  out  1: at least one nonzero word was seen.
- `first_nz_addr`  out  ADDR_W: address of the first nonzero word; 0 if none.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `mem_rwn`=0, so the memory's write path (`start`) is usable. On `go`=1:
  - latch the base address and count;
  - clear `checksum`, `nz_count`, `found_nz` and `first_nz_addr`;
  - go to ISSUE if `num_words`≠0, else go straight to DONE.
- ISSUE: `mem_rwn`=1 and `mem_addr`=base+i. Index i runs from 0 to N−1, one per cycle.
  - Address arithmetic is mod 2^ADDR_W: base 0xFFFF with N=3 reads 0xFFFF, 0x0000, 0x0001.
  - After issuing i=N−1, go to DRAIN.
- DRAIN: `mem_rwn`=0. Capture the last outstanding read, then go to DONE.
- Data capture: a read issued in cycle k appears on `mem_rdata` in cycle k+1. The block samples it at the end of cycle k+1, using a one-deep delayed valid flag and a delayed address.
- On each captured word:
  - `checksum` += word (wraps, no saturation);
  - if word≠0: `nz_count`++;
  - if word≠0 and `found_nz`=0: set `found_nz` and load `first_nz_addr` with that word's address.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. Results hold until the next accepted `go`.
- `go` outside IDLE is ignored and is not queued.
- An N=2^ADDR_W scan covers the whole memory. `nz_count` can reach 65536, which is why it is ADDR_W+1 bits wide.
- No other master may drive `address_test`/`rwn` while `busy`=1. The block does not arbitrate.

## Timing
- Reset values: state IDLE, `mem_rwn`=0, `mem_addr`=0, `busy`=0, `done`=0, `checksum`=0, `nz_count`=0, `found_nz`=0, `first_nz_addr`=0.
- All outputs are registered.
- `go` is sampled at edge e0.
  - N≥1: ISSUE occupies cycles 1..N, DRAIN is cycle N+1, and `done` is high in cycle N+2. `busy` is high in cycles 1..N+2.
  - N=0: `done` and `busy` are high in cycle 1 only.
- Throughput: one word per cycle, with no bubbles.
- Reset asserted mid-scan: the block returns to IDLE immediately and `mem_rwn` drops. Partial results are discarded and no `done` pulse is produced.
- `go` in the same cycle as `done`: ignored, because the state is DONE. `go` is accepted one cycle later, in IDLE.

## Structure
- Shared package `mem_pkg`:
  - `ADDR_W`/`WORD_W` defaults;
  - the `scan_state_t` enum {IDLE, ISSUE, DRAIN, DONE};
  - the zero-word constant.
  The memory and the loader use the same width constants.
- One natural sub-module, `scan_addr_gen`. It holds the base register, the index counter, wrap-around addition, the last-issue flag, and the one-cycle delayed address/valid pipeline.
- The FSM and accumulators stay in the top module.

## Test plan
- **Basic scan:** preload addresses 0x0010..0x0013 with 1, 2, 0, 5; `go` with base 0x0010, N=4.
  - Required: `done` is high in cycle 6 after `go`.
  - `checksum`=8, `nz_count`=3, `found_nz`=1, `first_nz_addr`=0x0010.
- **Wrap and overflow:** preload 0xFFFF=0xFFFFFFFF and 0x0000=0x00000002; base 0xFFFF, N=2.
  - Required: `mem_addr` sequence 0xFFFF then 0x0000.
  - `checksum`=0x00000001, `nz_count`=2, `first_nz_addr`=0xFFFF.
- **All-zero region:** after reset, base 0x1234, N=16.
  - Required: `checksum`=0, `nz_count`=0, `found_nz`=0, `first_nz_addr`=0, `done` in cycle 18.
- **Zero count:** `go` with N=0.
  - Required: `done` and `busy` high in cycle 1 only, `mem_rwn` never rises, all results 0.
- **Ignored go and back-to-back:** pulse `go` during ISSUE with different base/N.
  - Required: the run completes with the original parameters.
  - A `go` held high through `done` starts the second scan in the cycle after `done`.
- **Reset mid-scan:** assert `reset` low in cycle 3 of an N=10 scan.
  - Required: `mem_rwn`, `busy` and the results are 0 asynchronously, and no `done` pulse is produced.
  - A later N=1 scan of a word holding 7 returns `checksum`=7.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, scan states and constants for the 64Kx32 memory,
// its loader and the read-back scan checker.
package mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_WORD_W = 32;

  localparam logic [DEF_WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/scan_addr_gen.sv
// Address walker for the scan: base + index with wrap, last-issue flag,
// and a one-deep delayed valid/address pipe matching the memory read latency.
module scan_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              issue,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              cap_valid,
  output logic [ADDR_W-1:0] cap_addr
);

  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(1);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              cap_valid_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [ADDR_W-1:0] idx_nxt;

  assign idx_nxt = idx_q + STEP;
  assign last    = ({1'b0, idx_q} == cnt_q - CNT_ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q      <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
    end else begin
      // data for the address issued now returns next cycle
      cap_valid_q <= issue;
      cap_addr_q  <= addr_q;
      if (load) begin
        base_q <= base_addr;
        cnt_q  <= num_words;
        idx_q  <= '0;
        addr_q <= base_addr;
      end else if (issue && !last) begin
        idx_q  <= idx_nxt;
        addr_q <= base_q + idx_nxt;
      end
    end
  end

  assign addr      = addr_q;
  assign cap_valid = cap_valid_q;
  assign cap_addr  = cap_addr_q;

endmodule

// File: rtl/mem_scan_checker.sv
// Read-back scanner: walks an address range through the memory test port
// and accumulates an additive checksum and a nonzero-word census.
module mem_scan_checker
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              mem_rwn,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] checksum,
  output logic [ADDR_W:0]   nz_count,
  output logic              found_nz,
  output logic [ADDR_W-1:0] first_nz_addr
);

  localparam logic [ADDR_W:0] NZ_ONE = (ADDR_W+1)'(1);

  scan_state_t state_q;
  scan_state_t state_d;

  logic              start;
  logic              issue;
  logic              last;
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_addr;
  logic              word_nz;

  logic              rwn_q;
  logic              busy_q;
  logic              done_q;
  logic [WORD_W-1:0] cs_q;
  logic [ADDR_W:0]   nz_q;
  logic              found_q;
  logic [ADDR_W-1:0] first_q;

  assign issue   = (state_q == ISSUE);
  assign word_nz = (mem_rdata != WORD_W'(ZERO_WORD));

  scan_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .issue    (issue),
    .base_addr(base_addr),
    .num_words(num_words),
    .addr     (mem_addr),
    .last     (last),
    .cap_valid(cap_valid),
    .cap_addr (cap_addr)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          start   = 1'b1;
          state_d = (num_words == '0) ? DONE : ISSUE;
        end
      end
      ISSUE:   if (last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rwn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= '0;
      nz_q    <= '0;
      found_q <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      rwn_q   <= (state_d == ISSUE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (start) begin
        cs_q    <= '0;
        nz_q    <= '0;
        found_q <= 1'b0;
        first_q <= '0;
      end else if (cap_valid) begin
        cs_q <= cs_q + mem_rdata;
        if (word_nz) begin
          nz_q <= nz_q + NZ_ONE;
          if (!found_q) begin
            found_q <= 1'b1;
            first_q <= cap_addr;
          end
        end
      end
    end
  end

  assign mem_rwn       = rwn_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign checksum      = cs_q;
  assign nz_count      = nz_q;
  assign found_nz      = found_q;
  assign first_nz_addr = first_q;

endmodule

// File: tb/tb_mem_scan_checker.sv
// Bench for mem_scan_checker: memory model, scan-level reference model,
// per-cycle compare process and directed/random scans.
module tb_mem_scan_checker;

  localparam int AW = 16;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          mem_rwn;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_rdata = '0;
  logic          busy;
  logic          done;
  logic [WW-1:0] checksum;
  logic [AW:0]   nz_count;
  logic          found_nz;
  logic [AW-1:0] first_nz_addr;

  logic [WW-1:0] mem [0:65535];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  mem_scan_checker dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .mem_rwn      (mem_rwn),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum),
    .nz_count     (nz_count),
    .found_nz     (found_nz),
    .first_nz_addr(first_nz_addr)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scan-level reference model
  int            cyc = 0;
  int            start_cyc = 0;
  int            done_cyc = -10;
  int            m_n = 0;
  logic [AW-1:0] m_base = '0;
  logic [WW-1:0] e_cs = '0;
  int            e_nz = 0;
  logic          e_found = 1'b0;
  logic [AW-1:0] e_first = '0;

  always @(posedge clk or negedge reset) begin : model
    logic [AW-1:0] a;
    logic [WW-1:0] w;
    if (!reset) begin
      start_cyc = 0;
      done_cyc  = -10;
      e_cs      = '0;
      e_nz      = 0;
      e_found   = 1'b0;
      e_first   = '0;
    end else begin
      cyc++;
      if (go && (cyc - 1) > done_cyc) begin
        m_base    = base_addr;
        m_n       = int'(num_words);
        start_cyc = cyc;
        done_cyc  = (m_n == 0) ? cyc : cyc + m_n + 1;
        e_cs      = '0;
        e_nz      = 0;
        e_found   = 1'b0;
        e_first   = '0;
        for (int i = 0; i < m_n; i++) begin
          a    = m_base + AW'(i);
          w    = mem[a];
          e_cs = e_cs + w;
          if (w != 0) begin
            e_nz++;
            if (!e_found) begin
              e_found = 1'b1;
              e_first = a;
            end
          end
        end
      end
    end
  end

  task automatic chk_results(input string tag);
    chk({tag, "_cs"}, checksum, e_cs);
    chk({tag, "_nz"}, nz_count, e_nz);
    chk({tag, "_found"}, found_nz, e_found);
    chk({tag, "_first"}, first_nz_addr, e_first);
  endtask

  always @(negedge clk) begin : compare
    int            rel;
    logic [AW-1:0] ea;
    if (!reset) begin
      chk("rst_rwn", mem_rwn, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cs", checksum, 0);
      chk("rst_nz", nz_count, 0);
      chk("rst_found", found_nz, 0);
      chk("rst_first", first_nz_addr, 0);
    end else if (cyc >= start_cyc && cyc <= done_cyc) begin
      rel = cyc - start_cyc;
      chk("scan_busy", busy, 1);
      chk("scan_done", done, cyc == done_cyc);
      chk("scan_rwn", mem_rwn, rel < m_n);
      if (rel < m_n) begin
        ea = m_base + AW'(rel);
        chk("scan_addr", mem_addr, ea);
      end
      if (cyc == done_cyc) chk_results("done");
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_rwn", mem_rwn, 0);
      chk_results("idle");
    end
  end

  task automatic start_go(input logic [AW-1:0] b, input int n);
    @(negedge clk);
    go        = 1'b1;
    base_addr = b;
    num_words = (AW+1)'(n);
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      go = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got none want done within %0d", limit);
    end
  endtask

  initial begin
    int            lat;
    int            c;
    logic          saw_done;
    logic [AW-1:0] q [$];
    logic [AW-1:0] b;
    int            n;

    for (int i = 0; i < 65536; i++) mem[i] = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    chk("init_cs", checksum, 0);
    chk("init_busy", busy, 0);

    // basic scan
    mem[16] = 1; mem[17] = 2; mem[18] = 0; mem[19] = 5;
    start_go(16'h0010, 4);
    wait_done(20, lat);
    chk("basic_lat", lat, 6);
    chk("basic_cs", checksum, 8);
    chk("basic_nz", nz_count, 3);
    chk("basic_found", found_nz, 1);
    chk("basic_first", first_nz_addr, 16'h0010);
    chk("basic_model_cs", e_cs, 8);

    // wrap and overflow
    mem[16'hFFFF] = 32'hFFFF_FFFF;
    mem[0]        = 32'h0000_0002;
    start_go(16'hFFFF, 2);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      go = 1'b0;
      if (mem_rwn) q.push_back(mem_addr);
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("wrap_lat", lat, 4);
    chk("wrap_nreads", q.size(), 2);
    if (q.size() == 2) begin
      chk("wrap_addr0", q[0], 16'hFFFF);
      chk("wrap_addr1", q[1], 16'h0000);
    end
    chk("wrap_cs", checksum, 32'h1);
    chk("wrap_nz", nz_count, 2);
    chk("wrap_first", first_nz_addr, 16'hFFFF);

    // zero count
    start_go(16'h0010, 0);
    @(negedge clk);
    go = 1'b0;
    chk("zero_done1", done, 1);
    chk("zero_busy1", busy, 1);
    chk("zero_rwn1", mem_rwn, 0);
    @(negedge clk);
    chk("zero_done2", done, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_cs", checksum, 0);
    chk("zero_nz", nz_count, 0);
    chk("zero_first", first_nz_addr, 0);

    // all-zero region after reset
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    start_go(16'h1234, 16);
    wait_done(40, lat);
    chk("allz_lat", lat, 18);
    chk("allz_cs", checksum, 0);
    chk("allz_nz", nz_count, 0);
    chk("allz_found", found_nz, 0);
    chk("allz_first", first_nz_addr, 0);

    // go during ISSUE is ignored
    for (int i = 0; i < 10; i++) mem[16'h0100 + i] = WW'(i + 1);
    start_go(16'h0100, 10);
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    go = 1'b1; base_addr = 16'h0010; num_words = 3;
    @(negedge clk); go = 1'b0;
    c = 4;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c++;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("ign_lat", lat, 12);
    chk("ign_cs", checksum, 55);
    chk("ign_nz", nz_count, 10);
    chk("ign_first", first_nz_addr, 16'h0100);

    // go held through done: second scan accepted the cycle after done
    start_go(16'h0010, 4);
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        c = i;
        break;
      end
    end
    chk("b2b_lat", c, 6);
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    chk("b2b_rwn", mem_rwn, 1);
    chk("b2b_addr", mem_addr, 16'h0010);
    wait_done(20, lat);
    chk("b2b_lat2", lat, 5);
    chk("b2b_cs", checksum, 8);

    // reset mid-scan
    for (int i = 0; i < 10; i++) mem[16'h0200 + i] = WW'(i + 3);
    start_go(16'h0200, 10);
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rwn", mem_rwn, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cs", checksum, 0);
    chk("mid_nz", nz_count, 0);
    chk("mid_found", found_nz, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("mid_no_done", saw_done, 0);
    mem[16'h0300] = 7;
    start_go(16'h0300, 1);
    wait_done(10, lat);
    chk("one_lat", lat, 3);
    chk("one_cs", checksum, 7);
    chk("one_nz", nz_count, 1);
    chk("one_first", first_nz_addr, 16'h0300);

    // randomized scans with stray go pulses
    for (int k = 0; k < 12; k++) begin
      b = AW'($urandom);
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++)
        mem[b + AW'(i)] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      start_go(b, n);
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (done) begin
          lat = i;
          break;
        end
        if ($urandom_range(0, 4) == 0) begin
          go        = 1'b1;
          base_addr = AW'($urandom);
          num_words = (AW+1)'($urandom_range(0, 50));
        end else begin
          go = 1'b0;
        end
      end
      go = 1'b0;
      chk("rand_lat", lat, (n == 0) ? 1 : n + 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // full-memory scan, every word nonzero
    for (int i = 0; i < 65536; i++) mem[i] = WW'(i + 1);
    start_go(16'h8000, 65536);
    wait_done(70000, lat);
    chk("full_lat", lat, 65538);
    chk("full_nz", nz_count, 17'h10000);
    chk("full_cs", checksum, 32'h8000_8000);
    chk("full_first", first_nz_addr, 16'h8000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
